// File: rtl/ucie_ctl_rx_flit_assembler.sv
// Purpose: collects NBYTES-wide RX beats into FLIT_BEATS-beat flits, stages each
//          flit for a one-cycle cancel window, then releases it or drops it.
// Latency: final beat at edge N, cancel sampled at edge N+1, o_fdi_pl_valid after N+1.
// Backpressure: none. Beats are accepted every enabled cycle. Disabling the stage
//          discards the partial and staged flits and pulses o_partial_drop.
module ucie_ctl_rx_flit_assembler #(
  parameter int NBYTES     = 8,
  parameter int FLIT_BEATS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic [NBYTES*8-1:0]            i_beat_data,
  input  logic                           i_beat_valid,
  input  logic                           i_flit_cancel,
  output logic [NBYTES*8*FLIT_BEATS-1:0] o_fdi_pl_flit,
  output logic                           o_fdi_pl_valid,
  output logic                           o_partial_drop,
  output logic [CNT_W-1:0]               o_flit_count,
  output logic [7:0]                     o_cancel_count
);

  localparam int W  = NBYTES * 8;
  localparam int F  = W * FLIT_BEATS;
  localparam int CW = $clog2(FLIT_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FLIT_BEATS - 1);

  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [F-1:0]     asm_q, asm_d;
  logic [F-1:0]     stg_q, stg_d;
  logic             stg_valid_q, stg_valid_d;
  logic [F-1:0]     flit_q, flit_d;
  logic             pl_valid_q, pl_valid_d;
  logic             pdrop_q, pdrop_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [7:0]       ccnt_q, ccnt_d;
  logic [F-1:0]     asm_merged;

  // Next-state logic: disable wins over everything; otherwise the cancel window
  // is resolved and the incoming beat is assembled in the same cycle.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    asm_d       = asm_q;
    stg_d       = stg_q;
    stg_valid_d = stg_valid_q;
    flit_d      = flit_q;
    pl_valid_d  = 1'b0;
    pdrop_d     = 1'b0;
    fcnt_d      = fcnt_q;
    ccnt_d      = ccnt_q;

    // Final beat is merged directly so staging sees the complete flit this cycle.
    asm_merged = asm_q;
    asm_merged[beat_cnt_q*W +: W] = i_beat_data;

    if (!i_enable) begin
      beat_cnt_d  = '0;
      stg_valid_d = 1'b0;
      pdrop_d     = (beat_cnt_q != '0) || stg_valid_q;
    end else begin
      if (stg_valid_q) begin
        stg_valid_d = 1'b0;
        if (i_flit_cancel) begin
          if (ccnt_q != 8'hFF) ccnt_d = ccnt_q + 8'd1;
        end else begin
          flit_d     = stg_q;
          pl_valid_d = 1'b1;
          fcnt_d     = fcnt_q + 1'b1;
        end
      end
      // Staging is always free here: FLIT_BEATS >= 2 keeps final beats apart.
      if (i_beat_valid) begin
        asm_d = asm_merged;
        if (beat_cnt_q == LAST_BEAT) begin
          stg_d       = asm_merged;
          stg_valid_d = 1'b1;
          beat_cnt_d  = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  // State and registered outputs; reset clears everything, so a mid-flit reset loses data silently.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      beat_cnt_q  <= '0;
      asm_q       <= '0;
      stg_q       <= '0;
      stg_valid_q <= 1'b0;
      flit_q      <= '0;
      pl_valid_q  <= 1'b0;
      pdrop_q     <= 1'b0;
      fcnt_q      <= '0;
      ccnt_q      <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      asm_q       <= asm_d;
      stg_q       <= stg_d;
      stg_valid_q <= stg_valid_d;
      flit_q      <= flit_d;
      pl_valid_q  <= pl_valid_d;
      pdrop_q     <= pdrop_d;
      fcnt_q      <= fcnt_d;
      ccnt_q      <= ccnt_d;
    end
  end

  assign o_fdi_pl_flit  = flit_q;
  assign o_fdi_pl_valid = pl_valid_q;
  assign o_partial_drop = pdrop_q;
  assign o_flit_count   = fcnt_q;
  assign o_cancel_count = ccnt_q;

endmodule
